button_pattern_receiver: RTL
============================

// Module: button_pattern_receiver
// PURPOSE
//  Input-side counterpart of the LED rotator: builds an 8-bit LED pattern from two push
//  buttons, one meaning '0' and one meaning '1'. Each raw button is synchronised, debounced
//  and edge-detected; presses are shifted in MSB-first.
//  After 8 presses the pattern is published with a 1-cycle valid strobe.
//  Output feeds the rotator's pattern load input on the board top level.
// PARAMETERS
//  DEBOUNCE_CYCLES  250_000     clocks an input must hold a new level (10 ms @ 25 MHz); >=2
//  TIMEOUT_CYCLES   50_000_000  max idle clocks between presses inside a frame (2 s); >=2
//  RESET_PATTERN    8'b00011111 value of pattern after reset
// PORTS
//  clk            in   1  system clock; one clock domain only
//  rst            in   1  one clock; reset is synchronous and active-high
//  btn_zero_raw   in   1  raw button, '0' bit, active-high, asynchronous, bouncy
//  btn_one_raw    in   1  raw button, '1' bit, active-high, asynchronous, bouncy
//  pattern        out  8  last complete pattern, registered
//  pattern_valid  out  1  1-cycle strobe, same cycle pattern takes its new value
//  frame_err      out  1  1-cycle strobe: partial frame discarded (timeout or both pressed)
//  busy           out  1  high while a frame is partially collected (state COLLECT)
//  bit_count      out  4  bits collected in current frame, 0..7
// BEHAVIOUR
//  Reset (rst=1 at clk edge): pattern=RESET_PATTERN; pattern_valid=0; frame_err=0; busy=0;
//   bit_count=0; shift reg=0; debounced levels=0; sync flops=0; timeout cnt=0; state=IDLE.
//   Reset mid-frame discards the partial frame and raises no frame_err.
//  Input path, per button: 2-flop synchroniser -> debouncer -> rising-edge detect.
//   Debounced level flips only after the synced level differs from it for DEBOUNCE_CYCLES
//   consecutive clocks. Any agreeing cycle clears the counter.
//   Press edge = debounced 0->1; release edges are ignored.
//   Latency: raw rise held stable -> shift register update = 2 + DEBOUNCE_CYCLES + 1 clocks.
//  FSM: IDLE, COLLECT.
//   IDLE: single press edge -> shift in bit, bit_count=1, timeout cnt=0, go COLLECT.
//   COLLECT: single press edge -> sr <= {sr[6:0], bit}, bit_count+1, timeout cnt=0.
//    On the 8th bit: pattern <= {sr[6:0], bit}, pattern_valid=1, bit_count=0, go IDLE.
//    No edge: timeout cnt+1. When it reaches TIMEOUT_CYCLES-1, discard the frame,
//    frame_err=1, bit_count=0, go IDLE. pattern is unchanged.
//  Both press edges in the same cycle:
//   In COLLECT: discard the frame, frame_err=1, go IDLE.
//   In IDLE: ignore the press; no error.
//  A button still held is not re-accepted; it needs a release and a new press.
//  The first bit pressed lands in pattern[7].
//  pattern changes only on a completed frame. Strobes never exceed 1 cycle.
//  Timeout counter is 32 bit and saturates; it is not active in IDLE.
// STRUCTURE
//  Shared package btn_rx_pkg: FSM state typedef (IDLE, COLLECT), FRAME_BITS=8,
//   default RESET_PATTERN constant shared with the LED rotator.
//  Sub-module button_debouncer (param DEBOUNCE_CYCLES; ports clk, rst, raw, level,
//   press_pulse). It holds the synchroniser, debounce counter and edge detector.
//   Instantiate it twice. Top holds the FSM, shift register and timeout counter.
// TESTING (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
//  1 Reset: pattern=8'h1F; valid, err, busy=0; bit_count=0. Raw pulses shorter than
//    4 clocks with bounce produce no bit.
//  2 Clean presses 1,0,1,0,0,1,0,1 -> pattern=8'hA5, one valid strobe, busy drops the same
//    cycle. Each shift occurs 7 clocks after the raw rise.
//  3 Bouncy press (3 toggles of 2 clocks, then stable high) -> exactly one bit accepted.
//  4 Three presses, then 100 idle clocks -> frame_err strobe, bit_count=0, pattern unchanged.
//    The next full frame 8'h0F is accepted.
//  5 Both buttons rise together mid-frame -> frame_err, IDLE. In IDLE -> no err, no bit.
//  6 rst asserted after 5 bits -> all reset values. The next 8 presses give a correct pattern
//    with no frame_err.

Source files
------------

// File: rtl/btn_rx_pkg.sv
// Shared definitions for the button pattern receiver and the LED rotator.
package btn_rx_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

  localparam int FRAME_BITS = 8;

  // Power-on LED pattern, also used by the rotator so both agree after reset.
  localparam logic [7:0] DEFAULT_RESET_PATTERN = 8'b0001_1111;

endpackage

// File: rtl/button_debouncer.sv
// One push-button input path: 2-flop synchroniser, debounce counter and
// rising-edge detector producing a single-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             level_prev;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for press (0->1) detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign press_pulse = level & ~level_prev;

endmodule

// File: rtl/button_pattern_receiver.sv
// Builds an 8-bit LED pattern from a '0' button and a '1' button, MSB first,
// and publishes each completed frame with a single-cycle valid strobe.
module button_pattern_receiver
  import btn_rx_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250_000,
  parameter int         TIMEOUT_CYCLES  = 50_000_000,
  parameter logic [7:0] RESET_PATTERN   = DEFAULT_RESET_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_zero_raw,
  input  logic       btn_one_raw,
  output logic [7:0] pattern,
  output logic       pattern_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] bit_count
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_BIT     = 4'(FRAME_BITS - 1);

  rx_state_e             state, state_nxt;
  logic [FRAME_BITS-1:0] sr, sr_nxt;
  logic [3:0]            bit_count_nxt;
  logic [31:0]           tcnt, tcnt_nxt;
  logic [7:0]            pattern_nxt;
  logic                  valid_nxt;
  logic                  err_nxt;

  logic level_zero, level_one;
  logic press_zero, press_one;
  logic single, both, bit_in;
  logic [FRAME_BITS-1:0] shifted;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_zero (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_zero_raw),
    .level       (level_zero),
    .press_pulse (press_zero)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_one (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_one_raw),
    .level       (level_one),
    .press_pulse (press_one)
  );

  assign single  = press_zero ^ press_one;
  assign both    = press_zero & press_one;
  assign bit_in  = press_one;
  assign shifted = {sr[FRAME_BITS-2:0], bit_in};
  assign busy    = (state == COLLECT);

  // State, shift register, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sr            <= '0;
      bit_count     <= '0;
      tcnt          <= '0;
      pattern       <= RESET_PATTERN;
      pattern_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      sr            <= sr_nxt;
      bit_count     <= bit_count_nxt;
      tcnt          <= tcnt_nxt;
      pattern       <= pattern_nxt;
      pattern_valid <= valid_nxt;
      frame_err     <= err_nxt;
    end
  end

  // Frame collection: shift on single presses, abort on timeout or simultaneous presses.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    bit_count_nxt = bit_count;
    tcnt_nxt      = tcnt;
    pattern_nxt   = pattern;
    valid_nxt     = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        // Simultaneous presses while idle are simply ignored.
        if (single) begin
          sr_nxt        = shifted;
          bit_count_nxt = 4'd1;
          tcnt_nxt      = '0;
          state_nxt     = COLLECT;
        end
      end
      COLLECT: begin
        if (both) begin
          err_nxt       = 1'b1;
          sr_nxt        = '0;
          bit_count_nxt = '0;
          tcnt_nxt      = '0;
          state_nxt     = IDLE;
        end else if (single) begin
          sr_nxt   = shifted;
          tcnt_nxt = '0;
          if (bit_count == LAST_BIT) begin
            pattern_nxt   = shifted;
            valid_nxt     = 1'b1;
            bit_count_nxt = '0;
            state_nxt     = IDLE;
          end else begin
            bit_count_nxt = bit_count + 4'd1;
          end
        end else if (tcnt == TIMEOUT_LAST) begin
          err_nxt       = 1'b1;
          sr_nxt        = '0;
          bit_count_nxt = '0;
          tcnt_nxt      = '0;
          state_nxt     = IDLE;
        end else if (tcnt != 32'hFFFF_FFFF) begin
          tcnt_nxt = tcnt + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
